// File: rtl/mfp_eic_core_if.sv
// rtl/mfp_eic_core_if.sv - register port bundle for the EIC core
interface mfp_eic_core_if;
  logic [2:0]  reg_addr;
  logic        reg_wr;
  logic [31:0] reg_wdata;
  logic [31:0] reg_rdata;

  modport master (output reg_addr, output reg_wr, output reg_wdata, input reg_rdata);
  modport slave  (input reg_addr, input reg_wr, input reg_wdata, output reg_rdata);
endinterface

// File: rtl/mfp_eic_core.sv
// rtl/mfp_eic_core.sv - external interrupt controller: capture, mask, prioritise, present RIPL
module mfp_eic_core #(
  parameter int EIC_CHANNELS = 32
) (
  input  logic                    HCLK,
  input  logic                    HRESETn,
  input  logic [EIC_CHANNELS-1:0] EIC_input,
  input  logic                    SI_IAck,
  input  logic [7:0]              SI_IPL,
  mfp_eic_core_if.slave           reg_bus,
  output logic                    EIC_Present,
  output logic [7:0]              EIC_Interrupt,
  output logic [5:0]              EIC_Vector,
  output logic [16:0]             EIC_Offset,
  output logic [3:0]              EIC_ShadowSet
);

  localparam int CH = EIC_CHANNELS;

  logic [CH-1:0] eifr_q, eifr_d;
  logic [CH-1:0] eimsk_q, eimsk_d;
  logic [CH-1:0] eisens_q, eisens_d;
  logic [CH-1:0] prev_q;
  logic [5:0]    eiack_q, eiack_d;
  logic [7:0]    int_q, int_d;
  logic [5:0]    vec_q, vec_d;
  logic          present_q;

  logic [CH-1:0] wbits;
  logic [CH-1:0] w1c, w1s, rise, ack_clr, req;
  logic          ack_valid;
  logic          found;
  logic [5:0]    win_idx;
  logic [31:0]   eifr_rd, eimsk_rd, eisens_rd;

  // Register view is 32 bits wide; channels beyond bit 31 are not software-reachable.
  generate
    if (CH < 32) begin : g_narrow
      assign wbits     = reg_bus.reg_wdata[CH-1:0];
      assign eifr_rd   = {{(32-CH){1'b0}}, eifr_q};
      assign eimsk_rd  = {{(32-CH){1'b0}}, eimsk_q};
      assign eisens_rd = {{(32-CH){1'b0}}, eisens_q};
    end else if (CH == 32) begin : g_exact
      assign wbits     = reg_bus.reg_wdata;
      assign eifr_rd   = eifr_q;
      assign eimsk_rd  = eimsk_q;
      assign eisens_rd = eisens_q;
    end else begin : g_wide
      assign wbits     = {{(CH-32){1'b0}}, reg_bus.reg_wdata};
      assign eifr_rd   = eifr_q[31:0];
      assign eimsk_rd  = eimsk_q[31:0];
      assign eisens_rd = eisens_q[31:0];
    end
  endgenerate

  always_comb begin
    reg_bus.reg_rdata = 32'd0;
    case (reg_bus.reg_addr)
      3'd0:    reg_bus.reg_rdata = eifr_rd;
      3'd2:    reg_bus.reg_rdata = eimsk_rd;
      3'd3:    reg_bus.reg_rdata = eisens_rd;
      3'd4:    reg_bus.reg_rdata = {16'd0, SI_IPL, 2'b00, eiack_q};
      default: reg_bus.reg_rdata = 32'd0;
    endcase
  end

  assign ack_valid = SI_IAck && (int_q != 8'd0);
  assign w1c  = (reg_bus.reg_wr && reg_bus.reg_addr == 3'd0) ? wbits : '0;
  assign w1s  = (reg_bus.reg_wr && reg_bus.reg_addr == 3'd1) ? wbits : '0;
  assign rise = EIC_input & ~prev_q;

  always_comb begin
    ack_clr = '0;
    for (int i = 0; i < CH; i++) begin
      ack_clr[i] = ack_valid && eisens_q[i] && (vec_q == 6'(i));
    end
  end

  // Edge channels: set sources beat clear sources. Level channels mirror the input.
  assign eifr_d = (~eisens_q & EIC_input)
                | (eisens_q & (rise | w1s | (eifr_q & ~(w1c | ack_clr))));

  assign eimsk_d  = (reg_bus.reg_wr && reg_bus.reg_addr == 3'd2) ? wbits : eimsk_q;
  assign eisens_d = (reg_bus.reg_wr && reg_bus.reg_addr == 3'd3) ? wbits : eisens_q;
  assign eiack_d  = ack_valid ? vec_q : eiack_q;

  // The channel being acked is hidden from this arbitration so it is not re-presented.
  assign req = eifr_q & eimsk_q & ~ack_clr;

  always_comb begin
    found   = 1'b0;
    win_idx = 6'd0;
    for (int i = 0; i < CH; i++) begin
      if (req[i]) begin
        found   = 1'b1;
        win_idx = 6'(i);
      end
    end
  end

  assign int_d = found ? ({2'b00, win_idx} + 8'd1) : 8'd0;
  assign vec_d = found ? win_idx : 6'd0;

  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      eifr_q    <= '0;
      eimsk_q   <= '0;
      eisens_q  <= '0;
      prev_q    <= '0;
      eiack_q   <= 6'd0;
      int_q     <= 8'd0;
      vec_q     <= 6'd0;
      present_q <= 1'b0;
    end else begin
      eifr_q    <= eifr_d;
      eimsk_q   <= eimsk_d;
      eisens_q  <= eisens_d;
      prev_q    <= EIC_input;
      eiack_q   <= eiack_d;
      int_q     <= int_d;
      vec_q     <= vec_d;
      present_q <= 1'b1;
    end
  end

  assign EIC_Present   = present_q;
  assign EIC_Interrupt = int_q;
  assign EIC_Vector    = vec_q;
  assign EIC_Offset    = 17'd0;
  assign EIC_ShadowSet = 4'd0;

endmodule
